hazard_ctrl: RTL and testbench

- Generates the stall and flush controls for the 5-stage pipeline.
- Its idex_flush output drives the flush input of the ID/EX control-zeroing mux.
- Detects load-use hazards, branch-taken redirects and data-memory wait states.
- Sequences multi-cycle fetch-flush penalties and keeps saturating performance counters plus a sticky memory-timeout flag.

---
 rtl/hazard_ctrl_pkg.sv | 12 +
 rtl/sat_counter.sv | 25 ++
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
// Register-index width, x0 index, flush counter width and hazard FSM states.
package hazard_ctrl_pkg;
  localparam int REG_W  = 5;
  localparam int X0     = 0;
  localparam int FCNT_W = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush control for the 5-stage pipeline: load-use bubbles, taken-branch
// squashes with extra fetch-flush cycles, data-memory freezes and perf counters.
module hazard_ctrl #(
  parameter int REG_W       = hazard_ctrl_pkg::REG_W,
  parameter int FLUSH_EXTRA = 1,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_regWrite,
  input  logic             ex_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             memwb_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);
  import hazard_ctrl_pkg::*;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e          state_q, state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               timeout_q, timeout_d;
  logic               load_use, mem_busy, flush_inc, stall_inc;

  assign load_use = ex_memRead && ex_regWrite && (ex_rd != REG_W'(X0)) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  assign mem_busy = dmem_req && !dmem_ready;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    flush_inc   = 1'b0;
    state_d     = state_q;
    fcnt_d      = fcnt_q;

    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
      state_d     = RUN;
      fcnt_d      = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          // A frozen cycle defers branch/load-use: EX is held and re-evaluated later.
          if (!mem_busy) begin
            if (ex_branch_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              flush_inc  = 1'b1;
              if (FLUSH_EXTRA > 0) begin
                state_d = FLUSH;
                fcnt_d  = FCNT_W'(FLUSH_EXTRA);
              end
            end else if (load_use) begin
              pc_write   = 1'b0;
              ifid_write = 1'b0;
              idex_flush = 1'b1;
            end
          end
        end
        FLUSH: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (!mem_busy) begin
            fcnt_d = fcnt_q - FCNT_W'(1);
            if (fcnt_q <= FCNT_W'(1)) begin
              state_d = RUN;
              fcnt_d  = '0;
            end
          end
        end
        default: begin
          state_d = RUN;
          fcnt_d  = '0;
        end
      endcase

      if (mem_busy) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        memwb_flush = 1'b1;
      end
    end
  end

  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    if (rst) begin
      timeout_d = 1'b0;
    end else if (mem_busy) begin
      wait_d = (wait_q == WAIT_LAST) ? wait_q : wait_q + WAIT_W'(1);
      if (wait_q == WAIT_LAST)
        timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      fcnt_q    <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_inc   = !rst && !pc_write;
  assign mem_timeout = timeout_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (stall_inc),
    .cnt_o   (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .clear_i (rst),
    .inc_i   (flush_inc),
    .cnt_o   (flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle-level reference model predicts every
// cycle's outputs, a monitor compares them on the falling edge.
module tb_hazard_ctrl;
  localparam int REG_W       = 5;
  localparam int FLUSH_EXTRA = 2;
  localparam int MEM_TIMEOUT = 3;
  localparam int CNT_W       = 6;
  localparam int MAXC        = (1 << CNT_W) - 1;

  typedef struct {
    bit             rst;
    bit [REG_W-1:0] rs1, rs2, rd;
    bit             use1, use2, mrd, rwr, taken, req, rdy;
  } stim_t;

  typedef struct packed {
    logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             mem_timeout;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, ex_memRead = 0, ex_regWrite = 0;
  logic ex_branch_taken = 0, dmem_req = 0, dmem_ready = 0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_timeout;

  hazard_ctrl #(.REG_W(REG_W), .FLUSH_EXTRA(FLUSH_EXTRA), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_flush(idex_flush), .exmem_write(exmem_write), .memwb_flush(memwb_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout));

  always #5 clk = ~clk;

  obs_t sb[$];
  int checks = 0;
  int passed = 0;

  // reference model state: remaining squash cycles, consecutive busy cycles, counters
  int m_left = 0, m_busy_run = 0, m_stall = 0, m_flush = 0;
  bit m_to = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input stim_t s);
    obs_t e;
    bit busy, lu;
    rst = s.rst; id_rs1 = s.rs1; id_rs2 = s.rs2; ex_rd = s.rd;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2; ex_memRead = s.mrd; ex_regWrite = s.rwr;
    ex_branch_taken = s.taken; dmem_req = s.req; dmem_ready = s.rdy;
    e.stall_cnt = CNT_W'(m_stall);
    e.flush_cnt = CNT_W'(m_flush);
    e.mem_timeout = m_to;
    if (s.rst) begin
      {e.pc_write, e.ifid_write, e.idex_write, e.exmem_write} = 4'b0000;
      {e.ifid_flush, e.idex_flush, e.memwb_flush} = 3'b111;
      m_left = 0; m_busy_run = 0; m_stall = 0; m_flush = 0; m_to = 0;
    end else begin
      busy = s.req && !s.rdy;
      lu = s.mrd && s.rwr && (s.rd != 0) &&
           ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
      {e.pc_write, e.ifid_write, e.idex_write, e.exmem_write} = 4'b1111;
      {e.ifid_flush, e.idex_flush, e.memwb_flush} = 3'b000;
      if (busy) begin
        {e.pc_write, e.ifid_write, e.idex_write, e.exmem_write} = 4'b0000;
        e.memwb_flush = 1;
        e.ifid_flush = (m_left > 0);
        e.idex_flush = (m_left > 0);
      end else if (m_left > 0) begin
        e.ifid_flush = 1; e.idex_flush = 1;
        m_left--;
      end else if (s.taken) begin
        e.ifid_flush = 1; e.idex_flush = 1;
        if (m_flush < MAXC) m_flush++;
        m_left = FLUSH_EXTRA;
      end else if (lu) begin
        e.pc_write = 0; e.ifid_write = 0; e.idex_flush = 1;
      end
      if (!e.pc_write && m_stall < MAXC) m_stall++;
      m_busy_run = busy ? m_busy_run + 1 : 0;
      if (m_busy_run >= MEM_TIMEOUT) m_to = 1;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      a = {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_flush,
           stall_cnt, flush_cnt, mem_timeout};
      checks++;
      if (a === e) passed++;
      else $display("FAIL cycle_out @%0t: got ctl=%b stall=%0d flush=%0d to=%b expected ctl=%b stall=%0d flush=%0d to=%b",
                    $time, a[2*CNT_W+7:2*CNT_W+1], a.stall_cnt, a.flush_cnt, a.mem_timeout,
                    e[2*CNT_W+7:2*CNT_W+1], e.stall_cnt, e.flush_cnt, e.mem_timeout);
    end
  end

  initial begin
    stim_t s, r, lu;
    @(posedge clk); #1;
    r = idle(); r.rst = 1;
    repeat (2) step(r);
    step(idle());
    chk("reset_stall_cnt", int'(stall_cnt), 0);
    chk("reset_flush_cnt", int'(flush_cnt), 0);
    chk("reset_timeout", int'(mem_timeout), 0);

    // load-use on rs2
    lu = idle(); lu.mrd = 1; lu.rwr = 1; lu.rd = 5; lu.rs2 = 5; lu.use2 = 1;
    step(lu);
    step(idle());
    chk("loaduse_stall_cnt", int'(stall_cnt), 1);

    // x0 destination and unused operand never stall
    s = idle(); s.mrd = 1; s.rwr = 1; s.rd = 0; s.rs1 = 0; s.use1 = 1; s.rs2 = 0; s.use2 = 1;
    step(s);
    s = idle(); s.mrd = 1; s.rwr = 1; s.rd = 7; s.rs1 = 7; s.use1 = 0;
    step(s);
    chk("no_stall_x0_unused", int'(stall_cnt), 1);

    // taken branch, load-use pattern during the squash window is ignored
    s = idle(); s.taken = 1;
    step(s);
    step(lu);
    step(lu);
    step(idle());
    chk("branch_flush_cnt", int'(flush_cnt), 1);
    chk("branch_no_stall", int'(stall_cnt), 1);

    // memory wait overlapping a taken branch
    step(r);
    s = idle(); s.req = 1; s.rdy = 0; s.taken = 1;
    repeat (4) step(s);
    chk("memwait_no_branch_yet", int'(flush_cnt), 0);
    s.rdy = 1;
    step(s);
    step(idle());
    step(idle());
    chk("memwait_stall_cnt", int'(stall_cnt), 4);
    chk("memwait_flush_cnt", int'(flush_cnt), 1);

    // timeout boundary: 2 busy cycles stay clear, 3 set it sticky
    step(r);
    s = idle(); s.req = 1;
    repeat (2) step(s);
    step(idle());
    chk("timeout_2_busy", int'(mem_timeout), 0);
    step(r);
    repeat (3) step(s);
    chk("timeout_3_busy", int'(mem_timeout), 1);
    step(idle());
    chk("timeout_sticky", int'(mem_timeout), 1);

    // reset in the middle of the squash window
    s = idle(); s.taken = 1;
    step(s);
    step(idle());
    step(r);
    step(idle());
    chk("rst_midflush_stall", int'(stall_cnt), 0);
    chk("rst_midflush_flush", int'(flush_cnt), 0);

    // randomized traffic, long enough to saturate the small counters
    for (int i = 0; i < 800; i++) begin
      s.rst   = ($urandom_range(99) < 2);
      s.rs1   = REG_W'($urandom_range(3));
      s.rs2   = REG_W'($urandom_range(3));
      s.rd    = REG_W'($urandom_range(3));
      s.use1  = $urandom_range(1);
      s.use2  = $urandom_range(1);
      s.mrd   = $urandom_range(1);
      s.rwr   = ($urandom_range(3) != 0);
      s.taken = ($urandom_range(99) < 15);
      s.req   = ($urandom_range(99) < 35);
      s.rdy   = $urandom_range(1);
      step(s);
    end
    step(idle());

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
